// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter.
// Holds the controller state encoding and the default bus widths.
package ram_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 4;

    // One transaction in flight at a time: IDLE accepts, WRITE/READ
    // drive the RAM for one cycle, READ_RESP returns the read word.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_RESP = 2'd3
    } state_t;

    // Requester identifiers used for grant and last-grant tracking.
    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for the RAM arbiter.
// master: requester drives valid/write/address/wdata, sees ready/rvalid/rdata.
// slave : arbiter side, the mirror image.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);

    logic                     valid;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     ready;
    logic                     rvalid;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output valid,
        output write,
        output address,
        output wdata,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  valid,
        input  write,
        input  address,
        input  wdata,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ram_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant selector (purely combinational).
// Ports: valid0/valid1 requests, last_grant id, grant = winning id.
module rr_arbiter_2
    import ram_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    // A lone requester always wins; on a tie the one not granted
    // last time wins. With no request the output is don't-care (0).
    always_comb begin
        grant = REQ_ID_0;
        unique case (1'b1)
            (valid0 && valid1):  grant = ~last_grant;
            (valid1 && !valid0): grant = REQ_ID_1;
            default:             grant = REQ_ID_0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a simple dual-port synchronous RAM.
// Ports: clock/reset, req0/req1 handshake bundles, RAM write/read ports, busy.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    ram_arbiter_if.slave             req0,
    ram_arbiter_if.slave             req1,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic                     ram_write_enable,
    output logic [DATA_WIDTH-1:0]    ram_data_write,
    output logic [ADDRESS_WIDTH-1:0] ram_read_address,
    output logic                     ram_read_enable,
    input  logic [DATA_WIDTH-1:0]    ram_data_read,
    output logic                     busy
);

    state_t                   state_q;
    state_t                   state_d;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     write_q;
    logic                     id_q;
    logic                     last_grant_q;

    logic                     grant_id;
    logic                     any_valid;
    logic                     accept;

    logic [ADDRESS_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0]    win_wdata;
    logic                     win_write;

    logic                     ready0;
    logic                     ready1;
    logic                     rvalid0;
    logic                     rvalid1;
    logic                     we;
    logic                     re;

    rr_arbiter_2 u_rr (
        .valid0     (req0.valid),
        .valid1     (req1.valid),
        .last_grant (last_grant_q),
        .grant      (grant_id)
    );

    assign any_valid   = req0.valid | req1.valid;
    assign win_address = grant_id ? req1.address : req0.address;
    assign win_wdata   = grant_id ? req1.wdata   : req0.wdata;
    assign win_write   = grant_id ? req1.write   : req0.write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            id_q         <= REQ_ID_0;
            last_grant_q <= REQ_ID_1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q       <= win_address;
                wdata_q      <= win_wdata;
                write_q      <= win_write;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
        end
    end

    // Every strobe is also held low while reset is high, so an
    // in-flight transaction is dropped without a trailing enable/pulse.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ready0  = 1'b0;
        ready1  = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        accept  = 1'b1;
                        ready0  = (grant_id == REQ_ID_0);
                        ready1  = (grant_id == REQ_ID_1);
                        state_d = win_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    we      = 1'b1;
                    state_d = IDLE;
                end
                READ: begin
                    re      = 1'b1;
                    state_d = READ_RESP;
                end
                READ_RESP: begin
                    rvalid0 = (id_q == REQ_ID_0);
                    rvalid1 = (id_q == REQ_ID_1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign req0.ready  = ready0;
    assign req1.ready  = ready1;
    assign req0.rvalid = rvalid0;
    assign req1.rvalid = rvalid1;

    // Read data is only forwarded alongside its pulse.
    assign req0.rdata = rvalid0 ? ram_data_read : '0;
    assign req1.rdata = rvalid1 ? ram_data_read : '0;

    assign ram_write_address = addr_q;
    assign ram_data_write    = wdata_q;
    assign ram_write_enable  = we;
    assign ram_read_address  = addr_q;
    assign ram_read_enable   = re;

    assign busy = (state_q != IDLE);

    // write_q documents the accepted direction; the FSM state carries it.
    logic unused_ok;
    assign unused_ok = write_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a synchronous RAM model.
// Inputs change on the falling edge; checks sample 1ns later.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] waddr;
    logic       we;
    logic [7:0] wdat;
    logic [3:0] raddr;
    logic       re;
    logic [7:0] rdat = 8'h00;
    logic       busy;
    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter_if r0 ();
    ram_arbiter_if r1 ();

    ram_arbiter dut (
        .clock             (clk),
        .reset             (rst),
        .req0              (r0),
        .req1              (r1),
        .ram_write_address (waddr),
        .ram_write_enable  (we),
        .ram_data_write    (wdat),
        .ram_read_address  (raddr),
        .ram_read_enable   (re),
        .ram_data_read     (rdat),
        .busy              (busy)
    );

    always @(posedge clk) begin
        if (we) mem[waddr] <= wdat;
        if (re) rdat <= mem[raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
        r0.valid = v; r0.write = w; r0.address = a; r0.wdata = d;
    endtask

    task automatic set1(input logic v, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
        r1.valid = v; r1.write = w; r1.address = a; r1.wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        set0(1'b1, 1'b0, 4'h0, 8'h00);
        set1(1'b0, 1'b0, 4'h0, 8'h00);

        // reset held: every output low even with a request pending
        cyc(); cyc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready0", r0.ready, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdat, 0);
        chk("rst_rvalid0", r0.rvalid, 0);

        // req0 write 9/C5 then read it back
        cyc(); rst = 0; set0(1'b1, 1'b1, 4'h9, 8'hC5); #1;
        chk("w9_ready0", r0.ready, 1);
        chk("w9_ready1", r1.ready, 0);
        chk("w9_busy_t", busy, 0);
        cyc(); set0(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("w9_we", we, 1);
        chk("w9_waddr", waddr, 4'h9);
        chk("w9_wdata", wdat, 8'hC5);
        chk("w9_busy", busy, 1);
        cyc(); set0(1'b1, 1'b0, 4'h9, 8'h00); #1;
        chk("w9_we_off", we, 0);
        chk("r9_ready0", r0.ready, 1);
        cyc(); set0(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("r9_re", re, 1);
        chk("r9_raddr", raddr, 4'h9);
        chk("r9_rvalid_early", r0.rvalid, 0);
        cyc(); #1;
        chk("r9_rvalid0", r0.rvalid, 1);
        chk("r9_rdata0", r0.rdata, 8'hC5);
        chk("r9_rvalid1", r1.rvalid, 0);
        chk("r9_re_off", re, 0);
        cyc(); #1;
        chk("r9_rvalid_end", r0.rvalid, 0);
        chk("r9_idle", busy, 0);

        // fresh reset, then simultaneous write (req0) and read (req1) to F
        cyc(); rst = 1;
        cyc(); rst = 0;
        set0(1'b1, 1'b1, 4'hF, 8'h09);
        set1(1'b1, 1'b0, 4'hF, 8'h00); #1;
        chk("tie_ready0", r0.ready, 1);
        chk("tie_ready1", r1.ready, 0);
        cyc(); set0(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("tie_we", we, 1);
        chk("tie_wait_ready1", r1.ready, 0);
        cyc(); #1;
        chk("tie_ready1_next", r1.ready, 1);
        cyc(); set1(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("tie_re", re, 1);
        cyc(); #1;
        chk("tie_rvalid1", r1.rvalid, 1);
        chk("tie_rdata1", r1.rdata, 8'h09);
        chk("tie_rvalid0", r0.rvalid, 0);

        // both always requesting reads of addr 1: grants alternate
        cyc();
        set0(1'b1, 1'b0, 4'h1, 8'h00);
        set1(1'b1, 1'b0, 4'h1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_ready0", i), r0.ready, (i % 2 == 0));
            chk($sformatf("rr%0d_ready1", i), r1.ready, (i % 2 == 1));
            cyc(); cyc(); #1;
            chk($sformatf("rr%0d_rvalid0", i), r0.rvalid, (i % 2 == 0));
            chk($sformatf("rr%0d_rvalid1", i), r1.rvalid, (i % 2 == 1));
            cyc();
        end
        set0(1'b0, 1'b0, 4'h0, 8'h00);
        set1(1'b0, 1'b0, 4'h0, 8'h00);

        // req1 alone (granted last) does two back-to-back writes
        cyc(); set1(1'b1, 1'b1, 4'h1, 8'h0F); #1;
        chk("b2b_ready1_a", r1.ready, 1);
        cyc(); set1(1'b1, 1'b1, 4'h2, 8'h03); #1;
        chk("b2b_ready1_busy", r1.ready, 0);
        chk("b2b_waddr_a", waddr, 4'h1);
        chk("b2b_wdata_a", wdat, 8'h0F);
        chk("b2b_we_a", we, 1);
        cyc(); #1;
        chk("b2b_ready1_b", r1.ready, 1);
        cyc(); set1(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("b2b_we_b", we, 1);
        chk("b2b_waddr_b", waddr, 4'h2);
        chk("b2b_wdata_b", wdat, 8'h03);
        cyc(); set0(1'b1, 1'b0, 4'h1, 8'h00); #1;
        chk("b2b_rd_ready0", r0.ready, 1);
        cyc(); set0(1'b0, 1'b0, 4'h0, 8'h00);
        cyc(); #1;
        chk("b2b_rd_rdata0", r0.rdata, 8'h0F);

        // reset while in READ aborts the response
        cyc(); set0(1'b1, 1'b0, 4'h2, 8'h00); #1;
        chk("ab_ready0", r0.ready, 1);
        cyc(); set0(1'b0, 1'b0, 4'h0, 8'h00); #1;
        chk("ab_re", re, 1);
        rst = 1;
        cyc(); rst = 0; #1;
        chk("ab_rvalid0", r0.rvalid, 0);
        chk("ab_re_off", re, 0);
        chk("ab_busy", busy, 0);
        cyc(); #1;
        chk("ab_rvalid0_late", r0.rvalid, 0);
        chk("ab_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
